// File: rtl/reservation_station_if.sv
// Dispatcher, CDB and ALU-issue signal bundle for reservation_station.
// master = environment side (dispatcher/CDB drivers, ALU sink); slave = the station.
interface reservation_station_if #(
    parameter int ROB_WIDTH = 3,
    parameter int OP_WIDTH  = 6
) ();
    logic                 rs_full;
    logic                 disp_valid;
    logic [OP_WIDTH-1:0]  disp_op;
    logic [31:0]          disp_vj;
    logic [31:0]          disp_vk;
    logic [ROB_WIDTH-1:0] disp_qj;
    logic [ROB_WIDTH-1:0] disp_qk;
    logic                 disp_qj_busy;
    logic                 disp_qk_busy;
    logic [31:0]          disp_imm;
    logic [31:0]          disp_pc;
    logic [ROB_WIDTH-1:0] disp_rob_id;
    logic                 cdb_alu_valid;
    logic [ROB_WIDTH-1:0] cdb_alu_rob_id;
    logic [31:0]          cdb_alu_value;
    logic                 cdb_lsb_valid;
    logic [ROB_WIDTH-1:0] cdb_lsb_rob_id;
    logic [31:0]          cdb_lsb_value;
    logic                 alu_valid;
    logic [OP_WIDTH-1:0]  alu_op;
    logic [31:0]          alu_v1;
    logic [31:0]          alu_v2;
    logic [31:0]          alu_imm;
    logic [31:0]          alu_pc;
    logic [ROB_WIDTH-1:0] alu_rob_id;

    modport master (
        input  rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id,
        output disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk, disp_qj_busy,
               disp_qk_busy, disp_imm, disp_pc, disp_rob_id,
               cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
               cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value
    );

    modport slave (
        output rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id,
        input  disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk, disp_qj_busy,
               disp_qk_busy, disp_imm, disp_pc, disp_rob_id,
               cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
               cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value
    );
endinterface

// File: rtl/reservation_station.sv
// ALU/branch reservation station: buffers dispatched ops, snoops both CDBs, issues one ready op per cycle.
// Define RS_AGE_ORDER_EN for oldest-first issue (age matrix); otherwise lowest-index ready entry issues.
module reservation_station #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_WIDTH = 3,
    parameter int OP_WIDTH  = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    reservation_station_if.slave  bus
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]   valid, ready, issue_cand, disp_we, issue_we;
    logic [OP_WIDTH-1:0]  op     [RS_SIZE];
    logic [31:0]          vj     [RS_SIZE];
    logic [31:0]          vk     [RS_SIZE];
    logic [31:0]          imm    [RS_SIZE];
    logic [31:0]          pc     [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_id [RS_SIZE];

    logic                 free_found, issue_found, disp_fire, issue_fire;
    logic [IDX_W-1:0]     free_idx, issue_idx;
    logic [32:0]          disp_j, disp_k;
    logic [CNT_W-1:0]     count_reg;

    logic                 cdb_alu_valid, cdb_lsb_valid;
    logic [ROB_WIDTH-1:0] cdb_alu_rob_id, cdb_lsb_rob_id;
    logic [31:0]          cdb_alu_value, cdb_lsb_value;

    assign cdb_alu_valid  = bus.cdb_alu_valid;
    assign cdb_alu_rob_id = bus.cdb_alu_rob_id;
    assign cdb_alu_value  = bus.cdb_alu_value;
    assign cdb_lsb_valid  = bus.cdb_lsb_valid;
    assign cdb_lsb_rob_id = bus.cdb_lsb_rob_id;
    assign cdb_lsb_value  = bus.cdb_lsb_value;

    // Returns {busy, value}; the ALU broadcast takes precedence when both CDBs carry the tag.
    function automatic logic [32:0] snoop(input logic busy, input logic [ROB_WIDTH-1:0] tag,
                                          input logic [31:0] value);
        if (busy && cdb_alu_valid && cdb_alu_rob_id == tag)
            return {1'b0, cdb_alu_value};
        if (busy && cdb_lsb_valid && cdb_lsb_rob_id == tag)
            return {1'b0, cdb_lsb_value};
        return {busy, value};
    endfunction

    assign disp_j = snoop(bus.disp_qj_busy, bus.disp_qj, bus.disp_vj);
    assign disp_k = snoop(bus.disp_qk_busy, bus.disp_qk, bus.disp_vk);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_AGE_ORDER_EN
    // age_row[r][c] = 1 means entry r is older than entry c.
    logic [RS_SIZE-1:0] age_row [RS_SIZE];

    always_comb begin
        issue_cand = ready;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (ready[j] && age_row[j][i])
                    issue_cand[i] = 1'b0;
            end
        end
    end
`else
    assign issue_cand = ready;
`endif

    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (issue_cand[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_fire  = rdy_in && !flush_in && bus.disp_valid && free_found;
    assign issue_fire = rdy_in && !flush_in && issue_found;

    always_comb begin
        disp_we  = '0;
        issue_we = '0;
        if (disp_fire)
            disp_we[free_idx] = 1'b1;
        if (issue_fire)
            issue_we[issue_idx] = 1'b1;
    end

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        logic                 valid_reg, qj_busy_reg, qk_busy_reg;
        logic [OP_WIDTH-1:0]  op_reg;
        logic [31:0]          vj_reg, vk_reg, imm_reg, pc_reg;
        logic [ROB_WIDTH-1:0] qj_reg, qk_reg, rob_id_reg;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                valid_reg   <= 1'b0;
                qj_busy_reg <= 1'b0;
                qk_busy_reg <= 1'b0;
                op_reg      <= '0;
                vj_reg      <= '0;
                vk_reg      <= '0;
                imm_reg     <= '0;
                pc_reg      <= '0;
                qj_reg      <= '0;
                qk_reg      <= '0;
                rob_id_reg  <= '0;
            end else if (flush_in) begin
                valid_reg <= 1'b0;
            end else if (rdy_in) begin
                if (disp_we[gi]) begin
                    valid_reg                <= 1'b1;
                    op_reg                   <= bus.disp_op;
                    {qj_busy_reg, vj_reg}    <= disp_j;
                    {qk_busy_reg, vk_reg}    <= disp_k;
                    qj_reg                   <= bus.disp_qj;
                    qk_reg                   <= bus.disp_qk;
                    imm_reg                  <= bus.disp_imm;
                    pc_reg                   <= bus.disp_pc;
                    rob_id_reg               <= bus.disp_rob_id;
                end else if (valid_reg) begin
                    {qj_busy_reg, vj_reg} <= snoop(qj_busy_reg, qj_reg, vj_reg);
                    {qk_busy_reg, vk_reg} <= snoop(qk_busy_reg, qk_reg, vk_reg);
                    if (issue_we[gi])
                        valid_reg <= 1'b0;
                end
            end
        end

        assign valid[gi]  = valid_reg;
        assign ready[gi]  = valid_reg && !qj_busy_reg && !qk_busy_reg;
        assign op[gi]     = op_reg;
        assign vj[gi]     = vj_reg;
        assign vk[gi]     = vk_reg;
        assign imm[gi]    = imm_reg;
        assign pc[gi]     = pc_reg;
        assign rob_id[gi] = rob_id_reg;

`ifdef RS_AGE_ORDER_EN
        logic [RS_SIZE-1:0] age_row_reg;

        // A new entry is younger than everything already resident.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                age_row_reg <= '0;
            end else if (rdy_in && !flush_in) begin
                if (disp_we[gi])
                    age_row_reg <= '0;
                else if (valid_reg)
                    age_row_reg <= age_row_reg | disp_we;
            end
        end

        assign age_row[gi] = age_row_reg;
`endif
    end

    logic                 alu_valid_reg;
    logic [OP_WIDTH-1:0]  alu_op_reg;
    logic [31:0]          alu_v1_reg, alu_v2_reg, alu_imm_reg, alu_pc_reg;
    logic [ROB_WIDTH-1:0] alu_rob_id_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_valid_reg  <= 1'b0;
            alu_op_reg     <= '0;
            alu_v1_reg     <= '0;
            alu_v2_reg     <= '0;
            alu_imm_reg    <= '0;
            alu_pc_reg     <= '0;
            alu_rob_id_reg <= '0;
            count_reg      <= '0;
        end else if (flush_in) begin
            alu_valid_reg <= 1'b0;
            count_reg     <= '0;
        end else if (!rdy_in) begin
            alu_valid_reg <= 1'b0;
        end else begin
            alu_valid_reg <= issue_found;
            if (issue_found) begin
                alu_op_reg     <= op[issue_idx];
                alu_v1_reg     <= vj[issue_idx];
                alu_v2_reg     <= vk[issue_idx];
                alu_imm_reg    <= imm[issue_idx];
                alu_pc_reg     <= pc[issue_idx];
                alu_rob_id_reg <= rob_id[issue_idx];
            end
            count_reg <= count_reg + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    // One free slot of slack absorbs the dispatcher's one-cycle reaction to rs_full.
    assign bus.rs_full    = (count_reg >= CNT_W'(RS_SIZE - 1));
    assign bus.alu_valid  = alu_valid_reg;
    assign bus.alu_op     = alu_op_reg;
    assign bus.alu_v1     = alu_v1_reg;
    assign bus.alu_v2     = alu_v2_reg;
    assign bus.alu_imm    = alu_imm_reg;
    assign bus.alu_pc     = alu_pc_reg;
    assign bus.alu_rob_id = alu_rob_id_reg;
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: stimulus pushes expected issues, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_reservation_station;
    localparam int RS_SIZE   = 8;
    localparam int ROB_WIDTH = 3;
    localparam int OP_WIDTH  = 6;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic rdy   = 1'b1;
    logic flush = 1'b0;
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    reservation_station_if #(.ROB_WIDTH(ROB_WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

    reservation_station #(
        .RS_SIZE  (RS_SIZE),
        .ROB_WIDTH(ROB_WIDTH),
        .OP_WIDTH (OP_WIDTH)
    ) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .rdy_in  (rdy),
        .flush_in(flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  rob;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    function automatic logic [31:0] imm_of(input logic [2:0] rob);
        return 32'h100 + 32'(rob);
    endfunction

    function automatic logic [31:0] pc_of(input logic [2:0] rob);
        return 32'h1000 + {27'b0, rob, 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid    = 1'b0;
        bus.cdb_alu_valid = 1'b0;
        bus.cdb_lsb_valid = 1'b0;
    endtask

    task automatic drive_disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                              input logic [2:0] qj, input logic qjb,
                              input logic [2:0] qk, input logic qkb, input logic [2:0] rob);
        bus.disp_valid   = 1'b1;
        bus.disp_op      = op;
        bus.disp_vj      = vj;
        bus.disp_vk      = vk;
        bus.disp_qj      = qj;
        bus.disp_qj_busy = qjb;
        bus.disp_qk      = qk;
        bus.disp_qk_busy = qkb;
        bus.disp_rob_id  = rob;
        bus.disp_imm     = imm_of(rob);
        bus.disp_pc      = pc_of(rob);
    endtask

    task automatic cdb_alu(input logic [2:0] tag, input logic [31:0] val);
        bus.cdb_alu_valid  = 1'b1;
        bus.cdb_alu_rob_id = tag;
        bus.cdb_alu_value  = val;
    endtask

    task automatic cdb_lsb(input logic [2:0] tag, input logic [31:0] val);
        bus.cdb_lsb_valid  = 1'b1;
        bus.cdb_lsb_rob_id = tag;
        bus.cdb_lsb_value  = val;
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [2:0] rob, input int c);
        exp_t e;
        e.op  = op;
        e.v1  = v1;
        e.v2  = v2;
        e.imm = imm_of(rob);
        e.pc  = pc_of(rob);
        e.rob = rob;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every alu_valid cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.alu_valid === 1'b1) begin
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_issue: got rob=%0d op=%0d v1=%0h v2=%0h at cycle %0d, required no issue",
                         bus.alu_rob_id, bus.alu_op, bus.alu_v1, bus.alu_v2, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                if ({bus.alu_op, bus.alu_v1, bus.alu_v2, bus.alu_imm, bus.alu_pc, bus.alu_rob_id} !==
                    {mon_e.op, mon_e.v1, mon_e.v2, mon_e.imm, mon_e.pc, mon_e.rob}) begin
                    mismatched++;
                    $display("FAIL issue_data: got op=%0d v1=%0h v2=%0h imm=%0h pc=%0h rob=%0d, required op=%0d v1=%0h v2=%0h imm=%0h pc=%0h rob=%0d",
                             bus.alu_op, bus.alu_v1, bus.alu_v2, bus.alu_imm, bus.alu_pc, bus.alu_rob_id,
                             mon_e.op, mon_e.v1, mon_e.v2, mon_e.imm, mon_e.pc, mon_e.rob);
                end else begin
                    $display("issue rob=%0d op=%0d v1=%0h v2=%0h cycle=%0d", bus.alu_rob_id, bus.alu_op,
                             bus.alu_v1, bus.alu_v2, cyc);
                end
                if (mon_e.cyc >= 0) begin
                    compared++;
                    if (cyc != mon_e.cyc) begin
                        mismatched++;
                        $display("FAIL issue_cycle rob=%0d: got cycle %0d, required cycle %0d",
                                 mon_e.rob, cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        drive_disp(6'd0, 32'd0, 32'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        bus.disp_valid = 1'b0;
        cdb_alu(3'd0, 32'd0);
        cdb_lsb(3'd0, 32'd0);
        idle();

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #2;
        check("reset_rs_full", 32'(bus.rs_full), 32'd0);
        check("reset_alu_valid", 32'(bus.alu_valid), 32'd0);
        check("reset_alu_v1", bus.alu_v1, 32'd0);
        check("reset_alu_rob_id", 32'(bus.alu_rob_id), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: both operands ready -> issue the next cycle
        drive_disp(6'd1, 32'd5, 32'd7, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2);
        tick();
        expect_issue(6'd1, 32'd5, 32'd7, 3'd2, cyc + 1);
        idle();
        repeat (3) tick();
        check("t1_rs_full", 32'(bus.rs_full), 32'd0);

        // 2: rs1 pending on tag 3, resolved by ALU CDB
        drive_disp(6'd2, 32'hDEAD_BEEF, 32'd3, 3'd3, 1'b1, 3'd0, 1'b0, 3'd5);
        tick();
        idle();
        repeat (2) tick();
        cdb_alu(3'd3, 32'h10);
        tick();
        expect_issue(6'd2, 32'h10, 32'd3, 3'd5, cyc + 1);
        idle();
        repeat (3) tick();

        // 3: rs2 pending on tag 4, captured from LSB CDB in the dispatch cycle
        drive_disp(6'd3, 32'd9, 32'hDEAD_BEEF, 3'd0, 1'b0, 3'd4, 1'b1, 3'd6);
        cdb_lsb(3'd4, 32'hAB);
        tick();
        expect_issue(6'd3, 32'd9, 32'hAB, 3'd6, cyc + 1);
        idle();
        repeat (3) tick();

        // Both CDBs broadcast the same tag: ALU value wins
        drive_disp(6'd4, 32'hDEAD_BEEF, 32'd2, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4);
        tick();
        idle();
        cdb_alu(3'd1, 32'h111);
        cdb_lsb(3'd1, 32'h222);
        tick();
        expect_issue(6'd4, 32'h111, 32'd2, 3'd4, cyc + 1);
        idle();
        repeat (3) tick();

        // rdy low freezes issue and snooping
        drive_disp(6'd6, 32'hDEAD_BEEF, 32'h66, 3'd2, 1'b1, 3'd0, 1'b0, 3'd3);
        tick();
        drive_disp(6'd5, 32'h55, 32'h56, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1);
        tick();
        expect_issue(6'd5, 32'h55, 32'h56, 3'd1, cyc + 4);
        idle();
        rdy = 1'b0;
        cdb_alu(3'd2, 32'h99);
        repeat (3) tick();
        check("frozen_alu_valid", 32'(bus.alu_valid), 32'd0);
        rdy = 1'b1;
        idle();
        tick();
        tick();
        cdb_alu(3'd2, 32'h77);
        tick();
        expect_issue(6'd6, 32'h77, 32'h66, 3'd3, cyc + 1);
        idle();
        repeat (3) tick();

        // 5: flush with five entries, two of them ready, plus a dropped same-cycle dispatch
        for (int i = 0; i < 5; i++) begin
            drive_disp(6'(8 + i), 32'(i), 32'(i), (i < 2) ? 3'd6 : 3'd5, 1'b1, 3'd0, 1'b0, 3'(i));
            tick();
        end
        idle();
        cdb_alu(3'd6, 32'h66);
        tick();
        idle();
        flush = 1'b1;
        drive_disp(6'd20, 32'd1, 32'd2, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7);
        tick();
        flush = 1'b0;
        idle();
        check("t5_alu_valid_after_flush", 32'(bus.alu_valid), 32'd0);
        check("t5_rs_full_after_flush", 32'(bus.rs_full), 32'd0);
        repeat (3) tick();

        // 4: fill all entries; rs_full at 7, 8th accepted, 9th ignored
        for (int i = 0; i < 8; i++) begin
            drive_disp(6'(16 + i), 32'(i), 32'(100 + i), 3'd7, 1'b1, 3'd0, 1'b0, 3'(i));
            tick();
            if (i == 5) check("t4_rs_full_at_6", 32'(bus.rs_full), 32'd0);
            if (i == 6) check("t4_rs_full_at_7", 32'(bus.rs_full), 32'd1);
        end
        drive_disp(6'd63, 32'd1, 32'd1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        tick();
        idle();
        check("t4_rs_full_at_8", 32'(bus.rs_full), 32'd1);
        repeat (2) tick();
        cdb_alu(3'd7, 32'h77);
        tick();
        for (int k = 0; k < 8; k++)
            expect_issue(6'(16 + k), 32'h77, 32'(100 + k), 3'(k), cyc + 1 + k);
        idle();
        repeat (10) tick();
        check("t4_rs_full_drained", 32'(bus.rs_full), 32'd0);

        // 6: C reuses idx0 freed by A; B (idx1) is older than C
        drive_disp(6'd30, 32'hDEAD_BEEF, 32'hA2, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1);
        tick();
        drive_disp(6'd31, 32'hB1, 32'hDEAD_BEEF, 3'd0, 1'b0, 3'd2, 1'b1, 3'd2);
        tick();
        idle();
        cdb_alu(3'd1, 32'h31);
        tick();
        expect_issue(6'd30, 32'h31, 32'hA2, 3'd1, cyc + 1);
        idle();
        tick();
        drive_disp(6'd32, 32'hC1, 32'hC2, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3);
        cdb_lsb(3'd2, 32'h42);
        tick();
        idle();
`ifdef RS_AGE_ORDER_EN
        expect_issue(6'd31, 32'hB1, 32'h42, 3'd2, cyc + 1);
        expect_issue(6'd32, 32'hC1, 32'hC2, 3'd3, cyc + 2);
`else
        expect_issue(6'd32, 32'hC1, 32'hC2, 3'd3, cyc + 1);
        expect_issue(6'd31, 32'hB1, 32'h42, 3'd2, cyc + 2);
`endif
        repeat (4) tick();

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
